// File: rtl/hilo_muldiv_unit_if.sv
//==============================================================================
// Module      : hilo_muldiv_unit_if
// Description : Request/response bundle between the execute stage and the
//               HI/LO multiply/divide unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Execute-stage side: issues operations and observes HI/LO.
  modport master (
    output start, funct, a, b, flush,
    input  busy, stall, done, illegal, hi, lo
  );

  // Unit side.
  modport slave (
    input  start, funct, a, b, flush,
    output busy, stall, done, illegal, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
//==============================================================================
// Module      : hilo_muldiv_unit
// Description : Iterative unsigned MULTU/DIVU unit owning the HI/LO pair.
//               One shift-add or shift-subtract iteration per cycle; HI/LO
//               are only written on completion.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  wire logic          clk,
  input  wire logic          rst,
  hilo_muldiv_unit_if.slave  bus
);

  localparam logic [5:0]       c_FUNCT_MULTU = 6'h19;
  localparam logic [5:0]       c_FUNCT_DIVU  = 6'h1B;
  localparam logic [CNT_W-1:0] c_LAST_ITER   = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_is_div;
  logic [2*WIDTH-1:0]   r_acc;     // MULTU: {partial product, multiplier}; DIVU: {rem, quot}
  logic [WIDTH-1:0]     r_opnd;    // MULTU: multiplicand; DIVU: divisor
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_illegal;

  logic                 w_is_multu;
  logic                 w_is_divu;
  logic                 w_legal;
  logic                 w_b_zero;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_step;

  assign w_is_multu = (bus.funct == c_FUNCT_MULTU);
  assign w_is_divu  = (bus.funct == c_FUNCT_DIVU);
  assign w_legal    = w_is_multu | w_is_divu;
  assign w_b_zero   = (bus.b == '0);

  // One iteration of the selected algorithm applied to the accumulator.
  always_comb begin
    // Multiply: add multiplicand to upper half when multiplier LSB set, then shift right.
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    // Divide: shift {rem, quot} left, trial-subtract, keep or restore.
    w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff     = w_rem_sh - {1'b0, r_opnd};
    if (w_diff[WIDTH]) begin
      w_div_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_div_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
    w_step = r_is_div ? w_div_next : w_mul_next;
  end

  // Control FSM, iteration datapath and HI/LO writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (bus.flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST_ITER) begin
              r_hi    <= w_step[2*WIDTH-1:WIDTH];
              r_lo    <= w_step[WIDTH-1:0];
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; flush blocks acceptance.
          r_state <= ST_IDLE;
          if (bus.start && !bus.flush) begin
            if (!w_legal) begin
              r_illegal <= 1'b1;
            end else begin
              r_is_div <= w_is_divu;
              r_acc    <= {{WIDTH{1'b0}}, (w_is_divu ? bus.a : bus.b)};
              r_opnd   <= w_is_divu ? bus.b : bus.a;
              r_cnt    <= '0;
              if (w_is_divu && w_b_zero) begin
                // Divide by zero resolves immediately without iterating.
                r_hi    <= bus.a;
                r_lo    <= '1;
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.illegal = r_illegal;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.stall   = r_busy | (bus.start & w_legal & ~w_b_zero & (r_state != ST_RUN));

endmodule

`default_nettype wire

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative unsigned multiply/divide unit. It executes MULTU (funct 'h19) and DIVU (funct 'h1B) and writes the HI/LO register pair.
- MFHI/MFLO read HI/LO, and this block is the writer side of that pair.
- Sits beside the ALU in the execute stage and raises stall while an operation is in flight.

Parameters:
- WIDTH, 32, operand width and width of HI/LO.
- CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when state is not RUN.
- funct  input  6  'h19 = MULTU, 'h1B = DIVU; any other value is illegal.
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- flush  input  1  synchronous abort of the in-flight operation.
- busy  output  1  high while state == RUN.
- stall  output  1  combinational: busy | (start & legal funct & b != 0 & state != RUN).
- done  output  1  one-cycle pulse when HI/LO have just been updated.
- illegal  output  1  one-cycle pulse when start arrives with an illegal funct.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE, counter = 0, all internal shadow registers = 0.
  - hi = 0, lo = 0, busy = 0, done = 0, illegal = 0.
- States are IDLE, RUN and DONE. DONE lasts exactly one cycle, with done = 1.
- Accept (edge E0, state IDLE or DONE, start = 1):
  - Latch a, b and the op.
  - Legal funct with b != 0 (or MULTU with any b): go to RUN, counter = 0.
  - DIVU with b == 0: go directly to DONE, hi = a, lo = 'hFFFFFFFF.
  - Illegal funct: stay in / go to IDLE, pulse illegal for one cycle, hi/lo unchanged.
- RUN, one iteration per edge, counter increments each edge:
  - MULTU: shift-add on a 2*WIDTH accumulator. Per edge, if the multiplier LSB is 1, add the multiplicand to the upper half, then shift the accumulator right by 1.
  - DIVU: restoring shift-subtract. Shift {rem, quot} left by 1, trial-subtract the divisor from rem, set the quotient bit if the result is non-negative (restore otherwise).
  - On the edge where counter == WIDTH-1: write the result to hi/lo and go to DONE.
    - MULTU: hi = product[63:32], lo = product[31:0].
    - DIVU: hi = remainder, lo = quotient.
- Latency: start sampled at E0, RUN during cycles 1..WIDTH, done high in cycle WIDTH+1 (33 with defaults).
- hi/lo change only on a completion edge or reset. Intermediate values are never visible on hi/lo.
- start while in RUN: ignored. No queuing, no illegal pulse.
- Start in DONE: accepted the same as in IDLE. Back-to-back operations therefore cost WIDTH+1 cycles each.
- flush = 1 in RUN: next edge goes to IDLE, counter = 0, hi/lo keep their previous values, no done pulse.
- flush in IDLE/DONE: no effect, except that start is ignored on the same edge. flush has priority over start.
- The simultaneous done edge and flush cannot occur; flush during DONE does not cancel the already-written result.
- All arithmetic is unsigned, modulo 2^WIDTH per half. No overflow flag.

Test Plan:
- MULTU a = 'hFFFFFFFF, b = 'hFFFFFFFF -> busy for 32 cycles, done in cycle 33, hi = 'hFFFFFFFE, lo = 'h00000001.
- DIVU a = 100, b = 7 -> done in cycle 33, lo = 14, hi = 2. Then a back-to-back MULTU 3×5 started in the DONE cycle -> hi = 0, lo = 15, 33 cycles later.
- DIVU a = 5, b = 0 -> no RUN, done in cycle 1, hi = 5, lo = 'hFFFFFFFF, stall never asserted.
- After MULTU 2×3 completes (lo = 6):
  - Start DIVU 9/3, pulse start again at cycle 5 -> ignored.
  - Flush at cycle 10 -> IDLE next cycle, hi = 0, lo = 6 retained, no done.
- start with funct = 'h20 -> illegal pulses one cycle, busy = 0, stall = 0, hi/lo unchanged.
- rst asserted asynchronously mid-cycle at RUN cycle 17 -> hi = lo = 0, busy = 0 immediately, without a clock edge. After release, DIVU 'hFFFFFFFF/1 -> lo = 'hFFFFFFFF, hi = 0.
